ram_dp: RTL and testbench
=========================

# ram_dp

Parametrised dual-port word memory: one write port with byte enables, one registered read port. It is the next generation of the team's single-word 32-bit latch and sits in the same datapath as scratch storage between pipeline stages. After reset it zeroes every word with a hardware init sweep, and holds off requests until the sweep finishes.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- clk  input  1  clock; all state updates on the falling edge
- rst  input  1  asynchronous, active-low reset
- we  input  1  write request
- waddr  input  ADDR_W  write address
- be  input  DATA_W/8  byte enables for write; bit i covers in[8i+7:8i]
- in  input  DATA_W  write data
- re  input  1  read request
- raddr  input  ADDR_W  read address
- out  output  DATA_W  read data register
- rvalid  output  1  one-cycle pulse: out was updated at this edge
- busy  output  1  init sweep in progress; requests ignored

## Operation
- Reset (rst=0, asynchronous): out=0, rvalid=0, busy=1, sweep counter=0, FSM=INIT. Memory contents are not cleared by reset itself.
- FSM states: INIT, READY.
  - INIT: each falling edge writes 0 to mem[cnt] and increments cnt. At the edge that writes DEPTH-1, the FSM moves to READY and busy is cleared.
  - READY: the FSM stays here until reset.
- Reset mid-sweep: the sweep restarts from address 0 after release. Words already cleared stay 0.
- Write (READY, we=1): for each i with be[i]=1, mem[waddr] byte i <= in byte i. Bytes with be[i]=0 are unchanged. be all-zero is a no-op.
- Read (READY, re=1): out <= mem[raddr] and rvalid=1 for that cycle.
- When re=0, out holds its last value and rvalid=0.
- While busy=1, we and re are ignored: no write occurs, out holds, and rvalid=0.
- Simultaneous read and write to different addresses: both are performed independently.
- Same-address read during write: behaviour is selected by the macro (see Configuration).

## Timing
- Sampling: inputs are sampled on the falling edge of clk.
- Read latency: out and rvalid change at the same falling edge that samples re. rvalid stays high for exactly one clock period per accepted read. Back-to-back reads give a continuous rvalid=1.
- Write visibility: a write at edge k is visible to a read sampled at edge k+1.
- Init duration: exactly DEPTH falling edges after rst release. The first request accepted is the one sampled at edge DEPTH+1.
- busy deasserts at edge DEPTH.

## Configuration
- RAM_BYPASS_EN defined:
  - A read and a write to the same address at the same edge return the new data on out.
  - Bytes with be[i]=1 come from in; bytes with be[i]=0 come from the old memory contents.
- RAM_BYPASS_EN undefined:
  - The same case returns the old contents (read-before-write).
  - The memory is still updated at that edge.

## Test plan
- Init sweep (ADDR_W=4): release rst and hold re=1, raddr=3 throughout.
  - rvalid=0 and busy=1 for 16 edges.
  - busy=0 after edge 16.
  - The read at edge 17 returns out=0x00000000 with rvalid=1.
- Byte-enable write:
  - Write 0xDEADBEEF to addr 5 with be=4'b1111, then 0x11223344 to addr 5 with be=4'b0101.
  - A read of addr 5 returns 0xDE22BE44.
- Same-address collision: mem[7]=0xAAAAAAAA; write 0x55555555 with be=4'b0011 and read addr 7 at the same edge.
  - With RAM_BYPASS_EN: out=0xAAAA5555.
  - Without RAM_BYPASS_EN: out=0xAAAAAAAA.
  - In both builds, the next read returns 0xAAAA5555.
- Reset mid-operation:
  - Assert rst while out=0x12345678 and rvalid=1: out=0 and rvalid=0 immediately, asynchronously.
  - Release rst: busy=1 again for 16 edges. All 16 words read back 0 afterwards.
- Requests during busy: we=1 to addr 2 with in=0xFFFFFFFF during the sweep.
  - After the sweep, a read of addr 2 returns 0.
  - The read issued during busy produces rvalid=0 and out unchanged.

Source files
------------

// File: rtl/ram_dp_if.sv
// Request/response bundle for ram_dp: write port with byte enables,
// read port, and the init-sweep busy flag.
interface ram_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     in;
    logic                  re;
    logic [ADDR_W-1:0]     raddr;
    logic [DATA_W-1:0]     out;
    logic                  rvalid;
    logic                  busy;

    modport master (
        output we, waddr, be, in, re, raddr,
        input  out, rvalid, busy
    );

    modport slave (
        input  we, waddr, be, in, re, raddr,
        output out, rvalid, busy
    );
endinterface

// File: rtl/ram_dp.sv
// Dual-port byte-enable word memory, falling-edge clocked, zeroed by a hardware
// sweep after reset. Define RAM_BYPASS_EN to forward same-address write data to reads.
module ram_dp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    ram_dp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NBYTE = DATA_W / 8;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                w_sweep_we;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   r_out;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep_we = rst;
                w_cnt_nxt  = r_cnt + ADDR_W'(1);
                if (r_cnt == '1)
                    w_state_nxt = ST_READY;
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign w_wr_en = (r_state == ST_READY) && bus.we;
    assign w_rd_en = (r_state == ST_READY) && bus.re;

    // Storage has no reset; the sweep is what clears it.
    always_ff @(negedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int unsigned i = 0; i < NBYTE; i++) begin
                if (bus.be[i])
                    r_mem[bus.waddr][8*i +: 8] <= bus.in[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rdata = r_mem[bus.raddr];
`ifdef RAM_BYPASS_EN
        if (w_wr_en && (bus.waddr == bus.raddr)) begin
            for (int unsigned i = 0; i < NBYTE; i++) begin
                if (bus.be[i])
                    w_rdata[8*i +: 8] = bus.in[8*i +: 8];
            end
        end
`endif
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_out    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_en;
            if (w_rd_en)
                r_out <= w_rdata;
        end
    end

    assign bus.out    = r_out;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = (r_state == ST_INIT);
endmodule

// File: tb/tb_ram_dp.sv
// Directed self-checking bench for ram_dp (DATA_W=32, ADDR_W=4); expected
// values are hand-computed, with the collision result chosen by RAM_BYPASS_EN.
module tb_ram_dp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    ram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_if ();

    ram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance to just after the next active (falling) edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_coll;
        n_chk  = 0;
        n_pass = 0;
        rst            = 1'b0;
        u_if.we        = 1'b0;
        u_if.waddr     = '0;
        u_if.be        = '0;
        u_if.in        = '0;
        u_if.re        = 1'b0;
        u_if.raddr     = '0;

        #2;
        chk("rst_out",    u_if.out,    32'h0);
        chk("rst_rvalid", 32'(u_if.rvalid), 32'h0);
        chk("rst_busy",   32'(u_if.busy),   32'h1);

        // Init sweep with a read and a write held active the whole time.
        u_if.re    = 1'b1;
        u_if.raddr = 4'd3;
        u_if.we    = 1'b1;
        u_if.waddr = 4'd2;
        u_if.in    = 32'hFFFF_FFFF;
        u_if.be    = 4'b1111;
        #10 rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("init_rvalid_e%0d", k), 32'(u_if.rvalid), 32'h0);
            chk($sformatf("init_busy_e%0d", k), 32'(u_if.busy), (k < 16) ? 32'h1 : 32'h0);
            chk($sformatf("init_out_e%0d", k), u_if.out, 32'h0);
        end
        u_if.we = 1'b0;
        step();
        chk("first_rd_out",    u_if.out, 32'h0);
        chk("first_rd_rvalid", 32'(u_if.rvalid), 32'h1);
        u_if.raddr = 4'd2;
        step();
        chk("busy_wr_ignored", u_if.out, 32'h0);
        chk("b2b_rvalid",      32'(u_if.rvalid), 32'h1);
        u_if.re = 1'b0;

        // Byte-enable write merge.
        u_if.we    = 1'b1;
        u_if.waddr = 4'd5;
        u_if.in    = 32'hDEAD_BEEF;
        u_if.be    = 4'b1111;
        step();
        chk("wr_no_rvalid", 32'(u_if.rvalid), 32'h0);
        u_if.in = 32'h1122_3344;
        u_if.be = 4'b0101;
        step();
        u_if.we    = 1'b0;
        u_if.re    = 1'b1;
        u_if.raddr = 4'd5;
        step();
        chk("be_merge_out",    u_if.out, 32'hDE22_BE44);
        chk("be_merge_rvalid", 32'(u_if.rvalid), 32'h1);
        u_if.re = 1'b0;
        step();
        chk("hold_out",    u_if.out, 32'hDE22_BE44);
        chk("hold_rvalid", 32'(u_if.rvalid), 32'h0);

        // be all-zero is a no-op.
        u_if.we = 1'b1;
        u_if.be = 4'b0000;
        u_if.in = 32'h0;
        step();
        // Simultaneous write to 9 and read of 5.
        u_if.waddr = 4'd9;
        u_if.in    = 32'h0BAD_F00D;
        u_if.be    = 4'b1111;
        u_if.re    = 1'b1;
        u_if.raddr = 4'd5;
        step();
        chk("be_zero_noop", u_if.out, 32'hDE22_BE44);
        u_if.we    = 1'b0;
        u_if.raddr = 4'd9;
        step();
        chk("diff_addr_wr", u_if.out, 32'h0BAD_F00D);
        u_if.re = 1'b0;

        // Same-address collision.
        u_if.we    = 1'b1;
        u_if.waddr = 4'd7;
        u_if.in    = 32'hAAAA_AAAA;
        u_if.be    = 4'b1111;
        step();
        u_if.in    = 32'h5555_5555;
        u_if.be    = 4'b0011;
        u_if.re    = 1'b1;
        u_if.raddr = 4'd7;
        step();
`ifdef RAM_BYPASS_EN
        exp_coll = 32'hAAAA_5555;
`else
        exp_coll = 32'hAAAA_AAAA;
`endif
        chk("collision_out", u_if.out, exp_coll);
        u_if.we = 1'b0;
        step();
        chk("post_collision", u_if.out, 32'hAAAA_5555);

        // Reset mid-operation.
        u_if.re = 1'b0;
        u_if.we    = 1'b1;
        u_if.waddr = 4'd1;
        u_if.in    = 32'h1234_5678;
        u_if.be    = 4'b1111;
        step();
        u_if.we    = 1'b0;
        u_if.re    = 1'b1;
        u_if.raddr = 4'd1;
        step();
        chk("pre_rst_out",    u_if.out, 32'h1234_5678);
        chk("pre_rst_rvalid", 32'(u_if.rvalid), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out",    u_if.out, 32'h0);
        chk("async_rst_rvalid", 32'(u_if.rvalid), 32'h0);
        chk("async_rst_busy",   32'(u_if.busy), 32'h1);
        @(posedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("resweep_busy_e%0d", k), 32'(u_if.busy), (k < 16) ? 32'h1 : 32'h0);
            chk($sformatf("resweep_rvalid_e%0d", k), 32'(u_if.rvalid), 32'h0);
        end
        chk("resweep_out_held", u_if.out, 32'h0);
        for (int a = 0; a < 16; a++) begin
            u_if.raddr = 4'(a);
            step();
            chk($sformatf("clear_rd_a%0d", a), u_if.out, 32'h0);
            chk($sformatf("clear_rv_a%0d", a), 32'(u_if.rvalid), 32'h1);
        end
        u_if.re = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
